// File: rtl/bus_pkg.sv
// Shared constants for the 6502 bus responder: I/O page base, register
// offsets within the page, CTRL bit positions and the unmapped read value.
package bus_pkg;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hD000;

    localparam logic [7:0] RLD_LO = 8'h00;
    localparam logic [7:0] RLD_HI = 8'h01;
    localparam logic [7:0] CTRL   = 8'h02;
    localparam logic [7:0] STATUS = 8'h03;
    localparam logic [7:0] CNT_LO = 8'h04;
    localparam logic [7:0] CNT_HI = 8'h05;

    localparam int unsigned EN     = 0;
    localparam int unsigned AUTO   = 1;
    localparam int unsigned IRQ_EN = 2;

    localparam logic [7:0] UNMAPPED_RDATA = 8'hFF;

endpackage

// File: rtl/bus_responder_if.sv
// Core-side bus of the responder: address/data/strobes in, read data and irq out.
interface bus_responder_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wren;
    logic        cpu_read;
    logic [7:0]  cpu_rdata;
    logic        irq;

    modport master (
        output cpu_addr, cpu_wdata, cpu_wren, cpu_read,
        input  cpu_rdata, irq
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wren, cpu_read,
        output cpu_rdata, irq
    );
endinterface

// File: rtl/bus_responder_timer16.sv
// 16-bit down-counting timer with reload, CTRL and STATUS registers.
// Decoded write/clear strobes come from the responder top level.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | CTRL.en=0, counter holds
//   RUN     | CTRL.en=1, counter decrements every clock
module timer16
    import bus_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  wdata_i,
    input  logic        rld_lo_we_i,
    input  logic        rld_hi_we_i,
    input  logic        ctrl_we_i,
    input  logic        status_clr_i,
    output logic [15:0] count_o,
    output logic [15:0] reload_o,
    output logic [2:0]  ctrl_o,
    output logic        expired_o
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rld_q, rld_d;
    logic [0:0]  state_q, state_d;
    logic        auto_q, auto_d;
    logic        irq_en_q, irq_en_d;
    logic        expired_q, expired_d;
    logic        pend_q, pend_d;
    logic        expire;

    always_comb begin
        cnt_d    = cnt_q;
        rld_d    = rld_q;
        state_d  = state_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        pend_d   = 1'b0;
        expire   = 1'b0;

        if (rld_lo_we_i) rld_d[7:0]  = wdata_i;
        if (rld_hi_we_i) rld_d[15:8] = wdata_i;

        if (rld_hi_we_i) begin
            cnt_d = {wdata_i, rld_q[7:0]};
        end else if (state_q == ST_RUN) begin
            // pend_q marks the cycle after an auto-reload expiry
            if (pend_q) begin
                cnt_d = rld_q;
                if (rld_q == 16'h0000) expire = 1'b1;
            end else if (cnt_q == 16'h0001) begin
                cnt_d  = 16'h0000;
                expire = 1'b1;
            end else if (cnt_q == 16'h0000) begin
                cnt_d  = 16'hFFFF;
                expire = 1'b1;
            end else begin
                cnt_d = cnt_q - 16'h0001;
            end

            if (expire) begin
                if (auto_q) begin
                    pend_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'h0000;
                end
            end
        end

        if (ctrl_we_i) begin
            state_d  = wdata_i[EN];
            auto_d   = wdata_i[AUTO];
            irq_en_d = wdata_i[IRQ_EN];
        end

        if (expire)            expired_d = 1'b1;
        else if (status_clr_i) expired_d = 1'b0;
        else                   expired_d = expired_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= 16'h0000;
            rld_q     <= 16'h0000;
            state_q   <= ST_IDLE;
            auto_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            expired_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rld_q     <= rld_d;
            state_q   <= state_d;
            auto_q    <= auto_d;
            irq_en_q  <= irq_en_d;
            expired_q <= expired_d;
            pend_q    <= pend_d;
        end
    end

    assign count_o   = cnt_q;
    assign reload_o  = rld_q;
    assign ctrl_o    = {irq_en_q, auto_q, state_q};
    assign expired_o = expired_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the 6502 core: on-chip RAM, a timer I/O page
// and an unmapped default, with one-cycle registered read data.
module bus_responder
    import bus_pkg::*;
#(
    parameter int          RAM_AW  = 15,
    parameter logic [15:0] IO_BASE = IO_BASE_DEFAULT
) (
    input logic            clock,
    input logic            reset_n,
    bus_responder_if.slave bus
);
    logic [7:0]  off;
    logic        is_io, is_ram, io_we, ram_we;
    logic        status_clr, shadow_latch;
    logic [15:0] count, reload;
    logic [2:0]  ctrl;
    logic        expired;
    logic [7:0]  io_rd, rdata_d;

    logic [7:0]  io_rdata_q, ram_rd_q, cnt_hi_q;
    logic        ram_sel_q, irq_q;

    assign off    = bus.cpu_addr[7:0];
    assign is_io  = (bus.cpu_addr[15:8] == IO_BASE[15:8]);
    assign is_ram = !is_io && ((bus.cpu_addr >> RAM_AW) == 16'd0);
    assign io_we  = is_io && bus.cpu_wren;
    // reset_n gating keeps a write presented during reset from landing in RAM
    assign ram_we = is_ram && bus.cpu_wren && reset_n;

    assign status_clr = is_io && (off == STATUS) &&
                        (bus.cpu_read || (bus.cpu_wren && bus.cpu_wdata[0]));
    assign shadow_latch = is_io && bus.cpu_read && (off == CNT_LO);

    timer16 u_timer (
        .clock        (clock),
        .reset_n      (reset_n),
        .wdata_i      (bus.cpu_wdata),
        .rld_lo_we_i  (io_we && (off == RLD_LO)),
        .rld_hi_we_i  (io_we && (off == RLD_HI)),
        .ctrl_we_i    (io_we && (off == CTRL)),
        .status_clr_i (status_clr),
        .count_o      (count),
        .reload_o     (reload),
        .ctrl_o       (ctrl),
        .expired_o    (expired)
    );

    logic [7:0] mem_q [0:(1 << RAM_AW) - 1];

    always_ff @(posedge clock) begin
        if (ram_we) mem_q[bus.cpu_addr[RAM_AW-1:0]] <= bus.cpu_wdata;
        ram_rd_q <= mem_q[bus.cpu_addr[RAM_AW-1:0]];
    end

    always_comb begin
        io_rd = 8'h00;
        case (off)
            RLD_LO:  io_rd = reload[7:0];
            RLD_HI:  io_rd = reload[15:8];
            CTRL:    io_rd = {5'b00000, ctrl};
            STATUS:  io_rd = {7'b0000000, expired};
            CNT_LO:  io_rd = count[7:0];
            CNT_HI:  io_rd = cnt_hi_q;
            default: io_rd = 8'h00;
        endcase
    end

    assign rdata_d = is_io ? io_rd : UNMAPPED_RDATA;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_rdata_q <= 8'h00;
            ram_sel_q  <= 1'b0;
            cnt_hi_q   <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            io_rdata_q <= rdata_d;
            ram_sel_q  <= is_ram;
            if (shadow_latch) cnt_hi_q <= count[15:8];
            irq_q      <= expired && ctrl[IRQ_EN];
        end
    end

    assign bus.cpu_rdata = ram_sel_q ? ram_rd_q : io_rdata_q;
    assign bus.irq       = irq_q;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: a directed prologue followed by random
// bus traffic, each checked against a behavioural model of the memory map.
module tb_bus_responder;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    bus_responder_if bus ();

    bus_responder #(.RAM_AW(15), .IO_BASE(16'hD000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  rd;
        bit          rd_known;
        bit          irq;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // behavioural model of the memory map
    logic [15:0] m_rld, m_cnt;
    logic [7:0]  m_shadow;
    bit          m_en, m_auto, m_irqen, m_exp, m_pend;
    logic [7:0]  m_mem [int];

    task automatic model_reset();
        m_rld = 16'h0; m_cnt = 16'h0; m_shadow = 8'h0;
        m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0; m_pend = 0;
    endtask

    task automatic chk(input string nm, input logic [15:0] addr,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s addr=%h got=%h expected=%h at %0t", nm, addr, act, exp, $time);
        end
    endtask

    // one bus cycle: drive inputs, predict what the DUT shows after the next edge
    task automatic cycle(input logic [15:0] a, input logic [7:0] wd,
                         input bit we, input bit rd);
        exp_t e;
        bit io, ram, evt, n_en, n_pend, n_exp;
        logic [15:0] n_cnt;
        int off;
        @(negedge clock);
        #1;
        bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_wren = we; bus.cpu_read = rd;

        io  = (a[15:8] == 8'hD0);
        ram = !io && (a < 16'h8000);
        off = int'(a[7:0]);
        e.addr = a;
        e.rd_known = 1;
        e.rd = 8'h00;
        if (io) begin
            case (off)
                0: e.rd = m_rld[7:0];
                1: e.rd = m_rld[15:8];
                2: e.rd = {5'd0, m_irqen, m_auto, m_en};
                3: e.rd = {7'd0, m_exp};
                4: e.rd = m_cnt[7:0];
                5: e.rd = m_shadow;
                default: e.rd = 8'h00;
            endcase
        end else if (ram) begin
            if (m_mem.exists(int'(a))) e.rd = m_mem[int'(a)];
            else e.rd_known = 0;
        end else begin
            e.rd = 8'hFF;
        end
        e.irq = m_exp && m_irqen;
        sbq.push_back(e);

        evt = 0; n_cnt = m_cnt; n_en = m_en; n_pend = 0;
        if (io && we && off == 1) begin
            n_cnt = {wd, m_rld[7:0]};
        end else if (m_en) begin
            if (m_pend) begin
                n_cnt = m_rld;
                evt = (m_rld == 16'h0);
            end else if (m_cnt <= 16'h1) begin
                n_cnt = m_cnt - 16'h1;
                evt = 1;
            end else begin
                n_cnt = m_cnt - 16'h1;
            end
            if (evt && m_auto) n_pend = 1;
            if (evt && !m_auto) begin n_en = 0; n_cnt = 16'h0; end
        end

        n_exp = m_exp;
        if (io && off == 3 && (rd || (we && wd[0]))) n_exp = 0;
        if (evt) n_exp = 1;

        if (io && rd && off == 4) m_shadow = m_cnt[15:8];
        if (io && we && off == 0) m_rld[7:0] = wd;
        if (io && we && off == 1) m_rld[15:8] = wd;
        if (io && we && off == 2) begin
            n_en = wd[0]; m_auto = wd[1]; m_irqen = wd[2];
        end
        if (ram && we) m_mem[int'(a)] = wd;
        m_cnt = n_cnt; m_en = n_en; m_pend = n_pend; m_exp = n_exp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(16'hE000, 8'h00, 0, 0);
    endtask

    always @(negedge clock) begin
        if (reset_n && sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.rd_known) chk("rdata", e.addr, bus.cpu_rdata, e.rd);
            chk("irq", e.addr, {7'd0, bus.irq}, {7'd0, e.irq});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  wd;
        int          pick;

        bus.cpu_addr = 16'hE000; bus.cpu_wdata = 8'h00;
        bus.cpu_wren = 1'b0; bus.cpu_read = 1'b0;
        model_reset();
        #22;
        chk("reset_rdata", 16'h0, bus.cpu_rdata, 8'h00);
        chk("reset_irq", 16'h0, {7'd0, bus.irq}, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;

        // basic map
        cycle(16'h0000, 8'h3C, 1, 0);
        cycle(16'h0000, 8'h00, 0, 1);
        cycle(16'hD002, 8'h00, 0, 1);
        cycle(16'hE000, 8'h00, 0, 1);
        cycle(16'h8000, 8'h00, 0, 1);
        // RAM write, read-before-write
        cycle(16'h1234, 8'h55, 1, 0);
        cycle(16'h1234, 8'h00, 0, 1);
        cycle(16'h1234, 8'hAA, 1, 1);
        cycle(16'h1234, 8'h00, 0, 1);

        // auto-reload timer, reload 3
        cycle(16'hD000, 8'h03, 1, 0);
        cycle(16'hD001, 8'h00, 1, 0);
        cycle(16'hD002, 8'h07, 1, 0);
        idle(10);
        cycle(16'hD003, 8'h00, 0, 1);
        idle(3);

        // one-shot, reload 2
        cycle(16'hD002, 8'h00, 1, 0);
        cycle(16'hD000, 8'h02, 1, 0);
        cycle(16'hD001, 8'h00, 1, 0);
        cycle(16'hD002, 8'h05, 1, 0);
        idle(6);
        cycle(16'hD002, 8'h00, 0, 1);
        cycle(16'hD004, 8'h00, 0, 1);
        cycle(16'hD005, 8'h00, 0, 1);
        cycle(16'hD003, 8'h00, 0, 1);

        // CNT shadow at 0x0100
        cycle(16'hD002, 8'h00, 1, 0);
        cycle(16'hD000, 8'h00, 1, 0);
        cycle(16'hD001, 8'h01, 1, 0);
        cycle(16'hD004, 8'h00, 0, 1);
        cycle(16'hD002, 8'h01, 1, 0);
        idle(4);
        cycle(16'hD005, 8'h00, 0, 1);
        cycle(16'hD004, 8'h00, 0, 0);

        // expiry coinciding with STATUS W1C
        cycle(16'hD002, 8'h00, 1, 0);
        cycle(16'hD000, 8'h03, 1, 0);
        cycle(16'hD001, 8'h00, 1, 0);
        cycle(16'hD002, 8'h05, 1, 0);
        idle(2);
        cycle(16'hD003, 8'h01, 1, 0);
        cycle(16'hD003, 8'h00, 0, 0);

        // reload 0 with auto: expires every cycle
        cycle(16'hD000, 8'h00, 1, 0);
        cycle(16'hD001, 8'h00, 1, 0);
        cycle(16'hD002, 8'h07, 1, 0);
        cycle(16'hD003, 8'h00, 0, 1);
        cycle(16'hD003, 8'h00, 0, 1);
        cycle(16'hD003, 8'h00, 0, 1);

        // reset mid-count with a RAM write held during reset
        cycle(16'hD000, 8'h20, 1, 0);
        cycle(16'hD001, 8'h00, 1, 0);
        cycle(16'hD002, 8'h07, 1, 0);
        idle(5);
        @(negedge clock);
        #3;
        reset_n = 1'b0;
        bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'hEE;
        bus.cpu_wren = 1'b1; bus.cpu_read = 1'b0;
        #1;
        chk("midreset_rdata", 16'h0, bus.cpu_rdata, 8'h00);
        chk("midreset_irq", 16'h0, {7'd0, bus.irq}, 8'h00);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        bus.cpu_wren = 1'b0;
        reset_n = 1'b1;
        cycle(16'h0000, 8'h00, 0, 1);
        for (int i = 0; i < 6; i++) cycle(16'hD000 + 16'(i), 8'h00, 0, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 9));
            wd = 8'($urandom);
            if (pick <= 5) begin
                a = {8'hD0, 8'($urandom_range(0, 7))};
                if (a[7:0] == 8'h00) wd = 8'($urandom_range(0, 7));
                if (a[7:0] == 8'h01) wd = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            end else if (pick <= 7) begin
                a = 16'($urandom_range(0, 15)) | ((pick == 7) ? 16'h7FF0 : 16'h0000);
            end else if (pick == 8) begin
                a = {1'b1, 15'($urandom)};
                if (a[15:8] == 8'hD0) a = 16'hE000;
            end else begin
                a = 16'h1234;
            end
            cycle(a, wd, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        @(negedge clock);
        @(negedge clock);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
